// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: display fetch > clear engine > pixel writer.
// Define FB_CLEAR_EN to compile in the clear-screen engine.
module vga_fb_arbiter #(
  parameter int H_START = 400,
  parameter int V_START = 221,
  parameter int WIDTH   = 160,
  parameter int HEIGHT  = 120
) (
  input  logic        clk_25,
  input  logic        reset_n,
  input  logic [9:0]  h_count,
  input  logic [9:0]  v_count,
  output logic [14:0] ram_addr,
  output logic        ram_we,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata,
  output logic [7:0]  pixel,
  output logic        pixel_valid,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [7:0]  wr_x,
  input  logic [6:0]  wr_y,
  input  logic [7:0]  wr_data,
  input  logic        clr_start,
  input  logic [7:0]  clr_color,
  output logic        clr_busy
);

  function automatic logic [14:0] fb_addr(input logic [14:0] y, input logic [14:0] x);
    fb_addr = (y << 7) + (y << 5) + x;
  endfunction

  logic        fw_s;
  logic [14:0] fetch_addr_s;
  logic        wr_xfer_s;
  logic        wr_in_range_s;
  logic        fetch_d1_r;
  logic        fetch_d2_r;
  logic        clr_busy_s;
  logic        clr_write_s;

  assign fw_s = ({1'b0, h_count} >= 11'(H_START)) && ({1'b0, h_count} < 11'(H_START + WIDTH)) &&
                ({1'b0, v_count} >= 11'(V_START)) && ({1'b0, v_count} < 11'(V_START + HEIGHT));

  // Offsets are only meaningful inside the window, where they fit 8/7 bits.
  assign fetch_addr_s = fb_addr({5'd0, v_count} - 15'(V_START), {5'd0, h_count} - 15'(H_START));

  assign wr_in_range_s = ({1'b0, wr_x} < 9'(WIDTH)) && ({1'b0, wr_y} < 8'(HEIGHT));
  assign wr_ready      = reset_n & ~fw_s & ~clr_busy_s;
  assign wr_xfer_s     = wr_valid & wr_ready;
  assign clr_busy      = clr_busy_s;

`ifdef FB_CLEAR_EN
  localparam logic [14:0] LAST_ADDR = 15'(WIDTH * HEIGHT - 1);

  typedef enum logic {CLR_IDLE = 1'b0, CLR_RUN = 1'b1} clr_state_e;

  clr_state_e  state_r;
  clr_state_e  state_nxt_s;
  logic [14:0] clr_ptr_r;
  logic [7:0]  clr_color_r;

  // Clear FSM state register
  always_ff @(posedge clk_25 or negedge reset_n) begin
    if (!reset_n) state_r <= CLR_IDLE;
    else          state_r <= state_nxt_s;
  end

  // Clear FSM next state; the run ends with the write of the last pixel
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      CLR_IDLE: begin
        if (clr_start) state_nxt_s = CLR_RUN;
        else           state_nxt_s = CLR_IDLE;
      end
      CLR_RUN: begin
        if (!fw_s && (clr_ptr_r == LAST_ADDR)) state_nxt_s = CLR_IDLE;
        else                                   state_nxt_s = CLR_RUN;
      end
      default: state_nxt_s = CLR_IDLE;
    endcase
  end

  // Clear FSM outputs
  always_comb begin
    clr_busy_s  = 1'b0;
    clr_write_s = 1'b0;
    case (state_r)
      CLR_IDLE: begin
        clr_busy_s  = 1'b0;
        clr_write_s = 1'b0;
      end
      CLR_RUN: begin
        clr_busy_s  = 1'b1;
        clr_write_s = ~fw_s;
      end
      default: begin
        clr_busy_s  = 1'b0;
        clr_write_s = 1'b0;
      end
    endcase
  end

  // Clear pointer and latched fill colour
  always_ff @(posedge clk_25 or negedge reset_n) begin
    if (!reset_n) begin
      clr_ptr_r   <= 15'd0;
      clr_color_r <= 8'd0;
    end else if ((state_r == CLR_IDLE) && clr_start) begin
      clr_ptr_r   <= 15'd0;
      clr_color_r <= clr_color;
    end else if (clr_write_s) begin
      clr_ptr_r   <= clr_ptr_r + 15'd1;
    end
  end
`else
  logic [14:0] clr_ptr_r;
  logic [7:0]  clr_color_r;
  logic        unused_clr_s;

  assign clr_busy_s   = 1'b0;
  assign clr_write_s  = 1'b0;
  assign clr_ptr_r    = 15'd0;
  assign clr_color_r  = 8'd0;
  assign unused_clr_s = ^{clr_start, clr_color};
`endif

  // RAM port owner: fetch, then clear, then writer; idle cycles hold the address
  always_ff @(posedge clk_25 or negedge reset_n) begin
    if (!reset_n) begin
      ram_addr  <= 15'd0;
      ram_we    <= 1'b0;
      ram_wdata <= 8'd0;
    end else if (fw_s) begin
      ram_addr  <= fetch_addr_s;
      ram_we    <= 1'b0;
    end else if (clr_write_s) begin
      ram_addr  <= clr_ptr_r;
      ram_we    <= 1'b1;
      ram_wdata <= clr_color_r;
    end else if (wr_xfer_s && wr_in_range_s) begin
      ram_addr  <= fb_addr({8'd0, wr_y}, {7'd0, wr_x});
      ram_we    <= 1'b1;
      ram_wdata <= wr_data;
    end else begin
      ram_we    <= 1'b0;
    end
  end

  // Display pipeline: address edge, RAM read edge, pixel edge
  always_ff @(posedge clk_25 or negedge reset_n) begin
    if (!reset_n) begin
      fetch_d1_r  <= 1'b0;
      fetch_d2_r  <= 1'b0;
      pixel       <= 8'd0;
      pixel_valid <= 1'b0;
    end else begin
      fetch_d1_r  <= fw_s;
      fetch_d2_r  <= fetch_d1_r;
      pixel_valid <= fetch_d2_r;
      pixel       <= fetch_d2_r ? ram_rdata : 8'd0;
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter: behavioural RAM, reference image and a
// pixel scoreboard keyed by the cycle each fetched pixel is due.
`timescale 1ns/1ps
module tb_vga_fb_arbiter;
  localparam int H_START = 400;
  localparam int V_START = 221;
  localparam int WIDTH   = 160;
  localparam int HEIGHT  = 120;
  localparam int NPIX    = WIDTH * HEIGHT;

  logic        clk_25 = 1'b0;
  logic        reset_n = 1'b0;
  logic [9:0]  h_count = 10'd0;
  logic [9:0]  v_count = 10'd0;
  logic [14:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata = 8'd0;
  logic [7:0]  pixel;
  logic        pixel_valid;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [7:0]  wr_x = 8'd0;
  logic [6:0]  wr_y = 7'd0;
  logic [7:0]  wr_data = 8'd0;
  logic        clr_start = 1'b0;
  logic [7:0]  clr_color = 8'd0;
  logic        clr_busy;

  vga_fb_arbiter #(.H_START(H_START), .V_START(V_START), .WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
    .clk_25(clk_25), .reset_n(reset_n), .h_count(h_count), .v_count(v_count),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .pixel(pixel), .pixel_valid(pixel_valid), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data), .clr_start(clr_start),
    .clr_color(clr_color), .clr_busy(clr_busy)
  );

  always #20 clk_25 = ~clk_25;

  logic [7:0] ram_mem [0:NPIX-1];
  logic [7:0] ref_mem [0:NPIX-1];

  always @(posedge clk_25) begin
    if (ram_we && (int'(ram_addr) < NPIX)) ram_mem[ram_addr] <= ram_wdata;
    ram_rdata <= (int'(ram_addr) < NPIX) ? ram_mem[ram_addr] : 8'h00;
  end

  typedef struct packed { int due; logic [7:0] val; } exp_t;
  exp_t exp_q[$];
  int cyc = 0;
  int total = 0;
  int bad = 0;
  int valid_cnt = 0;
  int exp_last_addr = 0;

  always @(posedge clk_25) cyc <= cyc + 1;

  // Scoreboard: every negedge either pops a due pixel or expects an idle output
  always @(negedge clk_25) begin
    if (pixel_valid === 1'b1) valid_cnt++;
    total++;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      if (pixel_valid !== 1'b1 || pixel !== exp_q[0].val) begin
        bad++;
        $display("FAIL pixel cyc=%0d got valid=%b pixel=%h want valid=1 pixel=%h", cyc, pixel_valid, pixel, exp_q[0].val);
      end
      void'(exp_q.pop_front());
    end else if (pixel_valid !== 1'b0 || pixel !== 8'h00) begin
      bad++;
      $display("FAIL idle_pixel cyc=%0d got valid=%b pixel=%h want valid=0 pixel=00", cyc, pixel_valid, pixel);
    end
  end

  task automatic drive(input int h, input int v);
    @(negedge clk_25);
    h_count = 10'(h);
    v_count = 10'(v);
    if (h >= H_START && h < H_START + WIDTH && v >= V_START && v < V_START + HEIGHT) begin
      exp_t e;
      e.due = cyc + 3;
      e.val = ref_mem[(v - V_START) * WIDTH + (h - H_START)];
      exp_q.push_back(e);
      exp_last_addr = (v - V_START) * WIDTH + (h - H_START);
    end
  endtask

  task automatic run_lines(input int v0, input int v1, input int want_valid);
    int start_cnt;
    start_cnt = valid_cnt;
    for (int v = v0; v <= v1; v++)
      for (int h = H_START - 4; h < H_START + WIDTH + 4; h++) drive(h, v);
    repeat (4) drive(0, 0);
    total++;
    if (valid_cnt - start_cnt != want_valid) begin
      bad++;
      $display("FAIL valid_count got=%0d want=%0d", valid_cnt - start_cnt, want_valid);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d pending want=0", exp_q.size());
    end
  endtask

  task automatic check_ram(input string tag);
    int errs;
    errs = 0;
    for (int i = 0; i < NPIX; i++) if (ram_mem[i] !== ref_mem[i]) errs++;
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL ram_%s got=%0d differing bytes want=0", tag, errs);
    end
  endtask

  task automatic do_write(input int x, input int y, input logic [7:0] d);
    logic in_rng;
    in_rng = (x < WIDTH) && (y < HEIGHT);
    drive(0, 0);
    wr_valid = 1'b1; wr_x = 8'(x); wr_y = 7'(y); wr_data = d;
    #1;
    total++;
    if (wr_ready !== 1'b1) begin bad++; $display("FAIL wr_ready_blank got=%b want=1", wr_ready); end
    drive(0, 0);
    wr_valid = 1'b0;
    total++;
    if (ram_we !== in_rng) begin bad++; $display("FAIL write_we x=%0d y=%0d got=%b want=%b", x, y, ram_we, in_rng); end
    total++;
    if (in_rng) begin
      if (ram_addr !== 15'(y * WIDTH + x) || ram_wdata !== d) begin
        bad++;
        $display("FAIL write_port got addr=%0d data=%h want addr=%0d data=%h", ram_addr, ram_wdata, y * WIDTH + x, d);
      end
      ref_mem[y * WIDTH + x] = d;
      exp_last_addr = y * WIDTH + x;
    end else if (ram_addr !== 15'(exp_last_addr)) begin
      bad++;
      $display("FAIL drop_addr_hold got=%0d want=%0d", ram_addr, exp_last_addr);
    end
    drive(0, 0);
  endtask

  task automatic test_reset();
    drive(0, 0);
    total++;
    if (ram_addr !== 15'd0 || ram_we !== 1'b0 || ram_wdata !== 8'd0) begin
      bad++; $display("FAIL reset_port got addr=%0d we=%b data=%h want 0", ram_addr, ram_we, ram_wdata);
    end
    total++;
    if (clr_busy !== 1'b0 || wr_ready !== 1'b0) begin
      bad++; $display("FAIL reset_ctrl got busy=%b ready=%b want 0 0", clr_busy, wr_ready);
    end
    reset_n = 1'b1;
    #1;
    total++;
    if (wr_ready !== 1'b1) begin bad++; $display("FAIL ready_after_reset got=%b want=1", wr_ready); end
  endtask

  task automatic test_frame();
    run_lines(V_START - 1, V_START + HEIGHT, NPIX);
  endtask

  task automatic test_corner_write();
    do_write(WIDTH - 1, HEIGHT - 1, 8'h5A);
    run_lines(V_START + HEIGHT - 1, V_START + HEIGHT - 1, WIDTH);
  endtask

  task automatic test_out_of_range();
    do_write(WIDTH, 0, 8'hC3);
    do_write(3, HEIGHT, 8'hC4);
    check_ram("after_drop");
  endtask

  task automatic test_hold_window();
    int acc_h;
    logic exp_ready;
    acc_h = -1;
    for (int h = H_START - 4; h < H_START + WIDTH + 4; h++) begin
      drive(h, V_START + 5);
      if (acc_h >= 0 && wr_valid) begin
        wr_valid = 1'b0;
        total++;
        if (ram_we !== 1'b1 || ram_addr !== 15'd490 || ram_wdata !== 8'h77) begin
          bad++; $display("FAIL held_write got we=%b addr=%0d data=%h want 1 490 77", ram_we, ram_addr, ram_wdata);
        end
        ref_mem[490] = 8'h77;
        exp_last_addr = 490;
      end
      if (h > H_START && h <= H_START + WIDTH) begin
        total++;
        if (ram_we !== 1'b0) begin bad++; $display("FAIL window_we h=%0d got=%b want=0", h, ram_we); end
      end
      if (h == H_START) begin
        wr_valid = 1'b1; wr_x = 8'd10; wr_y = 7'd3; wr_data = 8'h77;
      end
      #1;
      exp_ready = !(h >= H_START && h < H_START + WIDTH);
      if (wr_valid) begin
        total++;
        if (wr_ready !== exp_ready) begin bad++; $display("FAIL hold_ready h=%0d got=%b want=%b", h, wr_ready, exp_ready); end
        if (wr_ready === 1'b1 && acc_h < 0) acc_h = h;
      end
    end
    wr_valid = 1'b0;
    repeat (4) drive(0, 0);
    total++;
    if (acc_h != H_START + WIDTH) begin bad++; $display("FAIL hold_accept_h got=%0d want=%0d", acc_h, H_START + WIDTH); end
    check_ram("after_hold");
  endtask

`ifdef FB_CLEAR_EN
  task automatic test_clear();
    int busy;
    int stall;
    drive(0, 0);
    clr_start = 1'b1; clr_color = 8'h3C;
    wr_valid = 1'b1; wr_x = 8'd5; wr_y = 7'd0; wr_data = 8'h99;
    #1;
    total++;
    if (wr_ready !== 1'b1) begin bad++; $display("FAIL clr_same_cycle_ready got=%b want=1", wr_ready); end
    drive(0, 0);
    clr_start = 1'b0; wr_valid = 1'b0;
    total++;
    if (ram_we !== 1'b1 || ram_addr !== 15'd5 || ram_wdata !== 8'h99 || clr_busy !== 1'b1) begin
      bad++; $display("FAIL clr_same_cycle_write got we=%b addr=%0d data=%h busy=%b want 1 5 99 1", ram_we, ram_addr, ram_wdata, clr_busy);
    end
    busy = 0; stall = 0;
    for (int i = 0; i < 20000 && clr_busy === 1'b1; i++) begin
      busy++;
      if (wr_ready !== 1'b0) stall++;
      drive(0, 0);
      clr_start = (i == 100);
      clr_color = 8'h55;
    end
    clr_start = 1'b0;
    total++;
    if (busy != NPIX) begin bad++; $display("FAIL clr_busy_cycles got=%0d want=%0d", busy, NPIX); end
    total++;
    if (stall != 0) begin bad++; $display("FAIL clr_writer_stall got=%0d ready cycles want=0", stall); end
    for (int i = 0; i < NPIX; i++) ref_mem[i] = 8'h3C;
    drive(0, 0);
    check_ram("after_clear");
    run_lines(V_START - 1, V_START + HEIGHT, NPIX);
  endtask

  task automatic test_clear_reset();
    drive(0, 0);
    clr_start = 1'b1; clr_color = 8'hE1;
    drive(0, 0);
    clr_start = 1'b0;
    total++;
    if (clr_busy !== 1'b1) begin bad++; $display("FAIL clr_restart_busy got=%b want=1", clr_busy); end
    repeat (500) drive(0, 0);
    reset_n = 1'b0;
    #1;
    total++;
    if (clr_busy !== 1'b0 || ram_we !== 1'b0) begin
      bad++; $display("FAIL clr_abort got busy=%b we=%b want 0 0", clr_busy, ram_we);
    end
    drive(0, 0);
    reset_n = 1'b1;
    repeat (3) drive(0, 0);
    total++;
    if (clr_busy !== 1'b0 || wr_ready !== 1'b1) begin
      bad++; $display("FAIL clr_after_abort got busy=%b ready=%b want 0 1", clr_busy, wr_ready);
    end
  endtask
`else
  task automatic test_clear_disabled();
    int errs;
    errs = 0;
    drive(0, 0);
    clr_start = 1'b1; clr_color = 8'hAA;
    drive(0, 0);
    clr_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (clr_busy !== 1'b0 || wr_ready !== 1'b1 || ram_we !== 1'b0) errs++;
      drive(0, 0);
    end
    total++;
    if (errs != 0) begin bad++; $display("FAIL clear_disabled got=%0d bad cycles want=0", errs); end
    check_ram("no_clear");
  endtask
`endif

  initial begin
    for (int i = 0; i < NPIX; i++) begin
      ram_mem[i] = 8'(i);
      ref_mem[i] = 8'(i);
    end
    test_reset();
    test_frame();
    test_corner_write();
    test_out_of_range();
    test_hold_window();
`ifdef FB_CLEAR_EN
    test_clear();
    test_clear_reset();
`else
    test_clear_disabled();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
